// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the fetch-address generator and its surroundings.
// Carries retire_cnt only when PC_RETIRE_CNT_EN is defined.
interface pc_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_target;
    logic            resume;
    logic [XLEN-1:0] pc;
    logic            pc_valid;
    logic            halt;
    logic [1:0]      halt_cause;
    logic [XLEN-1:0] fault_addr;
`ifdef PC_RETIRE_CNT_EN
    logic [63:0]     retire_cnt;
`endif

    modport master (
        output stall, redirect, redirect_target, resume,
        input  pc, pc_valid, halt, halt_cause, fault_addr
`ifdef PC_RETIRE_CNT_EN
        , input retire_cnt
`endif
    );

    modport slave (
        input  stall, redirect, redirect_target, resume,
        output pc, pc_valid, halt, halt_cause, fault_addr
`ifdef PC_RETIRE_CNT_EN
        , output retire_cnt
`endif
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-address generator with stall/redirect, run/halt FSM and fault capture.
// Optional retired-update counter enabled by defining PC_RETIRE_CNT_EN.
module pc_sequencer #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] START_ADDR = 32'h01000000,
    parameter logic [XLEN-1:0] LIMIT_ADDR = 32'h01000FFC,
    parameter int unsigned     ALIGN_BITS = 2
) (
    input logic           clk,
    input logic           rst,
    pc_sequencer_if.slave bus
);
    localparam logic [XLEN-1:0] Step = XLEN'(1) << ALIGN_BITS;

    typedef enum logic [0:0] {StRun, StHalted} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [1:0]      cause_q, cause_d;
    logic [XLEN-1:0] fault_q, fault_d;
    logic [XLEN-1:0] nxt;
    logic            mis, oor;
`ifdef PC_RETIRE_CNT_EN
    logic [63:0]     cnt_q;
    logic            retire_inc;
`endif

    always_comb begin
        nxt = pc_q + Step;
        if (bus.redirect) begin
            nxt = bus.redirect_target;
        end else if (bus.stall) begin
            nxt = pc_q;
        end
        mis = |nxt[ALIGN_BITS-1:0];
        // Wrapped increments land below START_ADDR and are caught here.
        oor = (nxt < START_ADDR) || (nxt > LIMIT_ADDR);
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cause_d = cause_q;
        fault_d = fault_q;
`ifdef PC_RETIRE_CNT_EN
        retire_inc = 1'b0;
`endif
        unique case (state_q)
            StRun: begin
                if (mis || oor) begin
                    state_d = StHalted;
                    cause_d = {oor, mis};
                    fault_d = nxt;
                end else begin
                    pc_d = nxt;
`ifdef PC_RETIRE_CNT_EN
                    retire_inc = !bus.redirect && !bus.stall;
`endif
                end
            end
            StHalted: begin
                // fault_addr stays for post-mortem inspection.
                if (bus.resume) begin
                    state_d = StRun;
                    pc_d    = START_ADDR;
                    cause_d = 2'b00;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            pc_q    <= START_ADDR;
            cause_q <= 2'b00;
            fault_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
            fault_q <= fault_d;
        end
    end

`ifdef PC_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (retire_inc) begin
            cnt_q <= cnt_q + 64'd1;
        end
    end

    assign bus.retire_cnt = cnt_q;
`endif

    assign bus.pc         = pc_q;
    assign bus.pc_valid   = (state_q == StRun);
    assign bus.halt       = (state_q == StHalted);
    assign bus.halt_cause = cause_q;
    assign bus.fault_addr = fault_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes expected post-edge state,
// a monitor pops and compares after each rising edge.
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.XLEN(32)) bus ();

    pc_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        valid;
        logic        halt;
        logic [1:0]  cause;
        logic [31:0] fault;
        logic [63:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic exp_t mk(string n, logic [31:0] p, logic v, logic h, logic [1:0] c,
                                logic [31:0] f, logic [63:0] k);
        exp_t e;
        e.name = n; e.pc = p; e.valid = v; e.halt = h; e.cause = c; e.fault = f; e.cnt = k;
        return e;
    endfunction

    task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] tgt,
                        input logic rs, input exp_t e);
        @(negedge clk);
        rst                 = r;
        bus.stall           = s;
        bus.redirect        = rd;
        bus.redirect_target = tgt;
        bus.resume          = rs;
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT state after each edge against the oldest expectation.
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            exp_t e;
            logic ok;
            e  = exp_q.pop_front();
            ok = (bus.pc === e.pc) && (bus.pc_valid === e.valid) && (bus.halt === e.halt) &&
                 (bus.halt_cause === e.cause) && (bus.fault_addr === e.fault);
`ifdef PC_RETIRE_CNT_EN
            ok = ok && (bus.retire_cnt === e.cnt);
`endif
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL %s: got pc=%h valid=%b halt=%b cause=%b fault=%h, want pc=%h valid=%b halt=%b cause=%b fault=%h",
                         e.name, bus.pc, bus.pc_valid, bus.halt, bus.halt_cause, bus.fault_addr,
                         e.pc, e.valid, e.halt, e.cause, e.fault);
`ifdef PC_RETIRE_CNT_EN
                $display("  %s retire_cnt got=%0d want=%0d", e.name, bus.retire_cnt, e.cnt);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.stall           = 1'b0;
        bus.redirect        = 1'b0;
        bus.redirect_target = '0;
        bus.resume          = 1'b0;

        // r  s  rd target        rs
        step(1, 0, 0, 32'h0,        0, mk("reset",      32'h01000000, 1, 0, 2'b00, 32'h0,        0));
        step(0, 0, 0, 32'h0,        0, mk("seq1",       32'h01000004, 1, 0, 2'b00, 32'h0,        1));
        step(0, 0, 0, 32'h0,        0, mk("seq2",       32'h01000008, 1, 0, 2'b00, 32'h0,        2));
        step(0, 0, 0, 32'h0,        0, mk("seq3",       32'h0100000C, 1, 0, 2'b00, 32'h0,        3));
        step(0, 1, 1, 32'h01000100, 0, mk("redir_stall",32'h01000100, 1, 0, 2'b00, 32'h0,        3));
        step(0, 1, 0, 32'h0,        0, mk("stall_hold", 32'h01000100, 1, 0, 2'b00, 32'h0,        3));
        step(0, 0, 0, 32'h0,        0, mk("seq4",       32'h01000104, 1, 0, 2'b00, 32'h0,        4));
        step(0, 0, 0, 32'h0,        0, mk("seq5",       32'h01000108, 1, 0, 2'b00, 32'h0,        5));
        step(0, 0, 1, 32'h01000102, 0, mk("misalign",   32'h01000108, 0, 1, 2'b01, 32'h01000102, 5));
        step(0, 0, 1, 32'h01000200, 0, mk("halt_redir", 32'h01000108, 0, 1, 2'b01, 32'h01000102, 5));
        step(0, 0, 0, 32'h0,        0, mk("halt_idle",  32'h01000108, 0, 1, 2'b01, 32'h01000102, 5));
        step(0, 0, 1, 32'h01000200, 1, mk("resume",     32'h01000000, 1, 0, 2'b00, 32'h01000102, 5));
        step(0, 0, 0, 32'h0,        1, mk("resume_run", 32'h01000004, 1, 0, 2'b00, 32'h01000102, 6));
        step(0, 0, 1, 32'h01000FF4, 0, mk("to_top",     32'h01000FF4, 1, 0, 2'b00, 32'h01000102, 6));
        step(0, 0, 0, 32'h0,        0, mk("top1",       32'h01000FF8, 1, 0, 2'b00, 32'h01000102, 7));
        step(0, 0, 0, 32'h0,        0, mk("limit",      32'h01000FFC, 1, 0, 2'b00, 32'h01000102, 8));
        step(0, 0, 0, 32'h0,        0, mk("past_limit", 32'h01000FFC, 0, 1, 2'b10, 32'h01001000, 8));
        step(0, 0, 0, 32'h0,        0, mk("held",       32'h01000FFC, 0, 1, 2'b10, 32'h01001000, 8));
        step(0, 0, 0, 32'h0,        1, mk("resume2",    32'h01000000, 1, 0, 2'b00, 32'h01001000, 8));
        step(0, 0, 1, 32'h00FFFFFC, 0, mk("below_start",32'h01000000, 0, 1, 2'b10, 32'h00FFFFFC, 8));
        step(0, 0, 0, 32'h0,        1, mk("resume3",    32'h01000000, 1, 0, 2'b00, 32'h00FFFFFC, 8));
        step(0, 1, 1, 32'h02000001, 0, mk("both_bad",   32'h01000000, 0, 1, 2'b11, 32'h02000001, 8));
        step(1, 0, 1, 32'h01000100, 1, mk("rst_halted", 32'h01000000, 1, 0, 2'b00, 32'h0,        0));
        step(0, 0, 0, 32'h0,        0, mk("post_rst",   32'h01000004, 1, 0, 2'b00, 32'h0,        1));

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
